// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divisor helper
// used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int unsigned uart_divisor(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage single-bit synchronizer with a parameterized reset value.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit-delayed start edge,
// one-cycle valid/ferr strobes, break lockout after a framing error.
module uart_rx #(
    parameter int unsigned Clock = 50_000_000,
    parameter int unsigned Baud  = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);

    import uart_pkg::*;

    localparam int unsigned Divisor = uart_divisor(Clock, Baud);
    localparam int unsigned Half    = Divisor / 2;
    localparam int unsigned CntW    = $clog2(Divisor);

    localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Divisor - 1);

    logic            rxs;
    uart_rx_state_t  state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            busy_q;
    logic            rxs_prev_q;
    logic [1:0]      arm_q;

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i(clock),
        .rst_i(reset),
        .d_i  (rxd),
        .q_o  (rxs)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            rxs_prev_q <= 1'b0;
            arm_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            // The synchronizer's reset-value ones are not real line state, so the
            // edge history ignores them; a line held low through reset cannot start a frame.
            arm_q      <= {arm_q[0], 1'b1};
            rxs_prev_q <= rxs & arm_q[1];
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs) begin
                        cnt_q   <= CntHalf;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (!rxs) begin
                            cnt_q   <= CntFull;
                            idx_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= CntFull;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        if (rxs) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period (20 clocks per bit).
module tb_uart_rx;

    localparam int BitT = 200;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    int         checks;
    int         errors;
    int         cyc;
    int         vcount;
    int         fcount;
    int         proto_err;
    int         last_vcyc;
    int         start_cyc;
    logic       rst_seen;
    logic [7:0] data_prev;
    logic [7:0] rx_q[$];

    uart_rx #(
        .Clock(2_000_000),
        .Baud (100_000)
    ) dut (
        .clock(clk),
        .reset(reset),
        .rxd  (rxd),
        .data (data),
        .valid(valid),
        .ferr (ferr),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc       = 0;
        vcount    = 0;
        fcount    = 0;
        proto_err = 0;
        last_vcyc = 0;
        rst_seen  = 1'b1;
        data_prev = 8'h00;
    end

    always @(posedge clk) begin
        cyc++;
        rst_seen = reset;
    end

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount++;
            rx_q.push_back(data);
            last_vcyc = cyc;
        end
        if (ferr === 1'b1) fcount++;
        if (valid === 1'b1 && ferr === 1'b1) proto_err++;
        if (data !== data_prev && valid !== 1'b1 && !rst_seen) proto_err++;
        data_prev = data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_t, input logic stop);
        @(negedge clk);
        start_cyc = cyc;
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_t);
        end
        rxd = stop;
        #(bit_t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int v0;
    int f0;
    int bad;

    initial begin
        checks = 0;
        errors = 0;
        rxd    = 1'b1;
        reset  = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(2);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ferr", 32'(ferr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        idle(20);

        // 0x55, exact timing; valid 191 cycles after detection, detection 2 after drive
        v0 = vcount; f0 = fcount;
        send_byte(8'h55, BitT, 1'b1);
        idle(10);
        check("x55_count", 32'(vcount - v0), 32'd1);
        check("x55_data", 32'(rx_q[v0]), 32'h55);
        check("x55_latency", 32'(last_vcyc - start_cyc), 32'd193);
        check("x55_ferr", 32'(fcount - f0), 32'd0);

        // back-to-back frames, 2% fast then 2% slow
        v0 = vcount; f0 = fcount;
        send_byte(8'h00, 196, 1'b1);
        send_byte(8'hFF, 196, 1'b1);
        send_byte(8'h00, 204, 1'b1);
        send_byte(8'hFF, 204, 1'b1);
        idle(40);
        check("ppm_count", 32'(vcount - v0), 32'd4);
        check("fast_d0", 32'(rx_q[v0]), 32'h00);
        check("fast_d1", 32'(rx_q[v0+1]), 32'hFF);
        check("slow_d0", 32'(rx_q[v0+2]), 32'h00);
        check("slow_d1", 32'(rx_q[v0+3]), 32'hFF);
        check("ppm_ferr", 32'(fcount - f0), 32'd0);

        // short low glitch, shorter than half a bit
        idle(20);
        v0 = vcount; f0 = fcount;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        idle(3);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        idle(20);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        check("glitch_valid", 32'(vcount - v0), 32'd0);
        check("glitch_ferr", 32'(fcount - f0), 32'd0);

        // framing error followed by a long break
        idle(20);
        v0 = vcount; f0 = fcount;
        send_byte(8'hA3, BitT, 1'b0);
        idle(20 * 20);
        check("brk_ferr", 32'(fcount - f0), 32'd1);
        check("brk_valid", 32'(vcount - v0), 32'd0);
        check("brk_data", 32'(data), 32'hFF);
        check("brk_busy", 32'(busy), 32'h1);
        rxd = 1'b1;
        idle(40);
        send_byte(8'h3C, BitT, 1'b1);
        idle(20);
        check("after_brk_count", 32'(vcount - v0), 32'd1);
        check("after_brk_data", 32'(rx_q[v0]), 32'h3C);
        check("after_brk_ferr", 32'(fcount - f0), 32'd1);

        // reset pulse during data bit 4 of 0x81
        idle(20);
        v0 = vcount; f0 = fcount;
        fork
            send_byte(8'h81, BitT, 1'b1);
            begin
                @(negedge clk);
                repeat (110) @(negedge clk);
                #1;
                check("rst_busy_before", 32'(busy), 32'h1);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check("rst_data", 32'(data), 32'h00);
                check("rst_valid", 32'(valid), 32'h0);
                check("rst_ferr", 32'(ferr), 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
            end
        join
        idle(60);
        check("rst_no_valid", 32'(vcount - v0), 32'd0);
        check("rst_no_ferr", 32'(fcount - f0), 32'd0);
        send_byte(8'h7E, BitT, 1'b1);
        idle(20);
        check("rst_next_count", 32'(vcount - v0), 32'd1);
        check("rst_next_q", 32'(rx_q[v0]), 32'h7E);
        check("rst_next_data", 32'(data), 32'h7E);

        // all 256 byte values, back-to-back at exact timing
        idle(20);
        v0 = vcount; f0 = fcount;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), BitT, 1'b1);
        end
        idle(20);
        check("loop_count", 32'(vcount - v0), 32'd256);
        bad = 0;
        for (int i = 0; i < 256 && i < vcount - v0; i++) begin
            if (rx_q[v0+i] !== 8'(i)) bad++;
        end
        check("loop_order", 32'(bad), 32'd0);
        check("loop_ferr", 32'(fcount - f0), 32'd0);

        check("protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
